// File: rtl/add_sub_pkg.sv
// Shared encodings for the up/down add/sub counter and its receive-side decoder.
// The direction encoding must match the counter's addsub input.
package add_sub_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        UNSYNC,
        ACQUIRE,
        LOCKED
    } dec_state_e;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DOWN,
        STEP_HOLD,
        STEP_ERR
    } step_class_e;

    function automatic logic is_legal_step(input step_class_e cls);
        return (cls == STEP_UP) || (cls == STEP_DOWN);
    endfunction

endpackage

// File: rtl/add_sub_step_classify.sv
// Combinational step classifier: compares a new counter sample against the
// previous one modulo 2^WIDTH and reports up, down, hold or illegal.
module add_sub_step_classify
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] value_i,
    output step_class_e      class_o
);

    // Unsigned subtraction wraps naturally, so max->0 is +1 and 0->max is -1.
    logic [WIDTH-1:0] delta;
    assign delta = value_i - prev_i;

    // NOTE: class_o gets a default before the branches so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        class_o = STEP_ERR;
        if (delta == WIDTH'(1)) begin
            class_o = STEP_UP;
        end else if (delta == {WIDTH{1'b1}}) begin
            class_o = STEP_DOWN;
        end else if (delta == '0) begin
            class_o = STEP_HOLD;
        end
    end

endmodule

// File: rtl/add_sub_decoder.sv
// Receive-side tracker for the add/sub counter: recovers the step direction,
// flags illegal steps, counts errors and reports lock, all registered.
module add_sub_decoder
    import add_sub_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [WIDTH-1:0]     value_i,
    input  logic                 valid_i,
    input  logic                 clear_i,
    output logic                 addsub_o,
    output logic                 dir_valid_o,
    output logic                 hold_o,
    output logic                 step_err_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);

    dec_state_e           state_q,     state_d;
    logic [WIDTH-1:0]     prev_q,      prev_d;
    logic [LCW-1:0]       lock_cnt_q,  lock_cnt_d;
    logic                 addsub_q,    addsub_d;
    logic                 dir_valid_q, dir_valid_d;
    logic                 hold_q,      hold_d;
    logic                 step_err_q,  step_err_d;
    logic                 locked_q,    locked_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    step_class_e step_class;

    add_sub_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev_i  (prev_q),
        .value_i (value_i),
        .class_o (step_class)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        lock_cnt_d  = lock_cnt_q;
        addsub_d    = addsub_q;
        locked_d    = locked_q;
        dir_valid_d = 1'b0;
        hold_d      = 1'b0;
        step_err_d  = 1'b0;
        err_count_d = err_count_q;

        if (valid_i) begin
            prev_d = value_i;
            if (state_q == UNSYNC) begin
                // The first sample only seeds the reference; nothing to classify yet.
                state_d = ACQUIRE;
            end else if (is_legal_step(step_class)) begin
                addsub_d    = (step_class == STEP_DOWN) ? DIR_DOWN : DIR_UP;
                dir_valid_d = 1'b1;
                if (state_q == ACQUIRE) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                    if (lock_cnt_d == LCW'(LOCK_COUNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end else if (step_class == STEP_HOLD) begin
                hold_d = 1'b1;
            end else begin
                step_err_d = 1'b1;
                lock_cnt_d = '0;
                state_d    = ACQUIRE;
                locked_d   = 1'b0;
                if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end
        end

        // Clear has the last word so a same-cycle error still leaves zero.
        if (clear_i) begin
            err_count_d = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the async reset clears outputs without a clock edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= UNSYNC;
            prev_q      <= '0;
            lock_cnt_q  <= '0;
            addsub_q    <= 1'b0;
            dir_valid_q <= 1'b0;
            hold_q      <= 1'b0;
            step_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            lock_cnt_q  <= lock_cnt_d;
            addsub_q    <= addsub_d;
            dir_valid_q <= dir_valid_d;
            hold_q      <= hold_d;
            step_err_q  <= step_err_d;
            locked_q    <= locked_d;
            err_count_q <= err_count_d;
        end
    end

    assign addsub_o    = addsub_q;
    assign dir_valid_o = dir_valid_q;
    assign hold_o      = hold_q;
    assign step_err_o  = step_err_q;
    assign locked_o    = locked_q;
    assign err_count_o = err_count_q;

endmodule

// File: doc/add_sub_decoder.md
Name: add_sub_decoder

Overview:
- Receive-side companion to the up/down add/sub counter.
- Samples the counter's WIDTH-bit output stream and recovers the per-step direction (addsub) the counter was driven with.
- Detects illegal steps and reports lock status to downstream checking and monitor logic.
- Sits on the consumer side of the counter output bus. Purely sequential tracker with a 1-cycle registered output latency.

Parameters:
- WIDTH, 4, counter value width; must be >= 2 (at WIDTH=1, +1 and -1 are indistinguishable).
- LOCK_COUNT, 2, consecutive legal ±1 steps required to assert locked_o (>= 1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- value_i  in  WIDTH  counter value being observed.
- valid_i  in  1  value_i sampled on this edge only when high.
- clear_i  in  1  synchronous clear of err_count_o.
- addsub_o  out  1  recovered direction of the last legal step: 0 = up (+1), 1 = down (-1).
- dir_valid_o  out  1  1-cycle pulse; addsub_o updated for a new legal step.
- hold_o  out  1  1-cycle pulse; sample equal to previous sample.
- step_err_o  out  1  1-cycle pulse; illegal step detected.
- locked_o  out  1  LOCK_COUNT consecutive legal steps seen with no error since.
- err_count_o  out  ERR_CNT_W  saturating count of illegal steps.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state UNSYNC; prev_q 0; lock_cnt 0.
  - Takes effect immediately, mid-stream included. The first sample after release is treated as the first-ever sample.
- valid_i low: state, prev_q, lock_cnt, addsub_o and locked_o hold; pulse outputs 0. Gaps of any length are transparent.
- States:
  - UNSYNC: first valid sample -> prev_q = value_i, go to ACQUIRE, no pulse outputs.
  - ACQUIRE: classify each valid sample. On a legal step, lock_cnt++. When lock_cnt reaches LOCK_COUNT, go to LOCKED and set locked_o on the same edge.
  - LOCKED: a legal step or hold keeps the lock. An error returns to ACQUIRE with lock_cnt = 0 and locked_o = 0 on the same edge.
- Classification, per valid sample in ACQUIRE/LOCKED: delta = value_i - prev_q, modulo 2^WIDTH.
  - delta == 1: up. addsub_o = 0, dir_valid_o pulse.
  - delta == 2^WIDTH-1: down. addsub_o = 1, dir_valid_o pulse.
  - delta == 0: hold_o pulse. No error; lock_cnt and state unchanged; addsub_o unchanged.
  - Otherwise: step_err_o pulse, err_count_o++, lock_cnt = 0. addsub_o unchanged.
  - prev_q = value_i in every case, so the decoder resyncs on the new value after an error.
- Wrap-around is legal: max -> 0 is up; 0 -> max is down.
- Direction may change on any step. A direction change is a legal step and does not affect lock.
- Latency: every output reflects the sample taken at edge k and is visible after edge k. No combinational path from inputs to outputs.
- err_count_o:
  - Saturates at 2^ERR_CNT_W-1; further errors still pulse step_err_o.
  - clear_i sets it to 0. clear_i wins over a same-cycle error (result 0).
  - clear_i does not affect state or lock.

Decomposition:
- Shared package add_sub_pkg:
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1, shared with the counter's addsub encoding.
  - typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} dec_state_e.
  - typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_ERR} step_class_e.
- One natural sub-module: add_sub_step_classify. Purely combinational; (prev, value) -> step_class_e; parameterised on WIDTH.
- FSM, counters and output registers stay in add_sub_decoder.

Test Plan:
1. Reset, then valid samples 14, 15, 0, 1 (WIDTH=4, LOCK_COUNT=2):
   - No pulses after 14.
   - dir_valid_o pulses after 15, 0 and 1, with addsub_o = 0 each time.
   - locked_o rises after sample 0 and stays high.
2. Samples 2, 1, 0, 15, 0:
   - addsub_o = 1, 1, 1, then 0.
   - locked_o high after sample 0. Direction flip 15 -> 0 keeps the lock; no step_err_o.
3. Locked at 5, then sample 9:
   - step_err_o pulse, err_count_o = 1, locked_o = 0 after that edge.
   - Samples 10, 11 relock after 11.
4. Sample 3, valid_i low for 5 cycles, then 4:
   - Outputs frozen and no pulses during the gap.
   - After 4: dir_valid_o pulse, addsub_o = 0.
5. Locked at 7, then 7, 7, 6:
   - Two hold_o pulses, locked_o stays 1, no error.
   - Then a dir_valid_o pulse with addsub_o = 1.
6. Drive 300 illegal jumps:
   - err_count_o saturates at 255.
   - clear_i asserted on an error cycle gives 0.
   - Then assert reset_ni = 0 mid-stream: all outputs 0 immediately, without waiting for a clock edge.
   - First sample after release produces no pulse.
